// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port and memory-side signals
// of mem_arbiter.
//   fetch : if_req, if_addr, if_flush -> if_gnt, if_valid, if_rdata, stall_if
//   data  : d_req, d_we, d_wstrb, d_addr, d_wdata -> d_gnt, d_valid, d_rdata, stall_mem
//   memory: mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata -> mem_rdata
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        stall_if;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        stall_mem;

  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_wstrb, d_addr, d_wdata,
           mem_rdata,
    input  if_gnt, if_valid, if_rdata, stall_if, d_gnt, d_valid, d_rdata,
           stall_mem, mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_wstrb, d_addr, d_wdata,
           mem_rdata,
    output if_gnt, if_valid, if_rdata, stall_if, d_gnt, d_valid, d_rdata,
           stall_mem, mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported synchronous memory between the
// instruction-fetch port and the data (load/store) port. Grants at most one
// port per cycle, issues the access to memory in the grant cycle, and routes
// the read data back to the owner LATENCY cycles later via a tag pipeline.
// Data has priority; fetch wins once it has been passed over STARVE_LIMIT
// times in a row.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset
//   bus   - mem_arbiter_if.slave (fetch, data and memory signal groups)
module mem_arbiter #(
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic is_store;
  } tag_t;

  logic [CNT_W-1:0] starve_cnt;
  tag_t             tags [LATENCY];
  tag_t             out_tag;

  logic        fetch_live_c;
  logic        fetch_pri_c;
  logic        if_gnt_c;
  logic        d_gnt_c;
  logic        mem_en_c;
  logic        mem_we_c;
  logic [3:0]  mem_wstrb_c;
  logic [31:0] mem_addr_c;
  logic [31:0] mem_wdata_c;
  logic        resp_live_c;
  logic        if_valid_c;
  logic        d_valid_c;
  logic [31:0] if_rdata_c;
  logic [31:0] d_rdata_c;

  // Grant decision: flush kills fetch, data wins unless fetch is starved.
  always_comb begin
    fetch_live_c = bus.if_req & ~bus.if_flush & ~reset;
    fetch_pri_c  = (starve_cnt == LIMIT);
    if_gnt_c     = fetch_live_c & (~bus.d_req | fetch_pri_c);
    d_gnt_c      = bus.d_req & ~reset & ~if_gnt_c;
  end

  // Memory command from the granted port; idle bus is all zeros.
  always_comb begin
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_wstrb_c = 4'b0;
    mem_addr_c  = 32'b0;
    mem_wdata_c = 32'b0;
    if (if_gnt_c) begin
      mem_en_c   = 1'b1;
      mem_addr_c = bus.if_addr;
    end else if (d_gnt_c) begin
      mem_en_c    = 1'b1;
      mem_we_c    = bus.d_we;
      mem_wstrb_c = bus.d_we ? bus.d_wstrb : 4'b0;
      mem_addr_c  = bus.d_addr;
      mem_wdata_c = bus.d_wdata;
    end
  end

  // Consecutive data grants while fetch waits; flush cycles neither count nor clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_gnt_c || !bus.if_req) begin
      starve_cnt <= '0;
    end else if (d_gnt_c && !bus.if_flush && !fetch_pri_c) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Tag pipeline; a flush invalidates every fetch tag moving through it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= '{valid: if_gnt_c | d_gnt_c,
                   owner: d_gnt_c ? OWN_DATA : OWN_FETCH,
                   is_store: d_gnt_c & bus.d_we};
      for (int i = 1; i < LATENCY; i++) begin
        tags[i]       <= tags[i-1];
        tags[i].valid <= tags[i-1].valid &
                         ~(bus.if_flush & (tags[i-1].owner == OWN_FETCH));
      end
    end
  end

  // Response routing at the tag output; emerging fetch tags die on flush.
  always_comb begin
    out_tag     = tags[LATENCY-1];
    resp_live_c = out_tag.valid & ~reset;
    if_valid_c  = resp_live_c & (out_tag.owner == OWN_FETCH) & ~bus.if_flush;
    d_valid_c   = resp_live_c & (out_tag.owner == OWN_DATA);
    if_rdata_c  = if_valid_c ? bus.mem_rdata : 32'b0;
    d_rdata_c   = (d_valid_c & ~out_tag.is_store) ? bus.mem_rdata : 32'b0;
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.stall_if  = bus.if_req & ~if_gnt_c;
  assign bus.stall_mem = bus.d_req & ~d_gnt_c;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wstrb = mem_wstrb_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.if_valid  = if_valid_c;
  assign bus.if_rdata  = if_rdata_c;
  assign bus.d_valid   = d_valid_c;
  assign bus.d_rdata   = d_rdata_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives four mem_arbiter instances (LATENCY 1..4,
// STARVE_LIMIT 3) with identical stimulus, each attached to its own memory
// model, and checks every cycle against a grant/response reference model.
module tb_mem_arbiter;

  localparam int NL    = 4;
  localparam int LIMIT = 3;
  localparam int LOGN  = 8192;

  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_FETCH = 2'd1;
  localparam logic [1:0] K_LOAD  = 2'd2;
  localparam logic [1:0] K_STORE = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic        o_if_gnt [NL];
  logic        o_d_gnt [NL];
  logic        o_stall_if [NL];
  logic        o_stall_mem [NL];
  logic        o_if_valid [NL];
  logic        o_d_valid [NL];
  logic [31:0] o_if_rdata [NL];
  logic [31:0] o_d_rdata [NL];
  logic        o_mem_en [NL];
  logic        o_mem_we [NL];
  logic [3:0]  o_mem_wstrb [NL];
  logic [31:0] o_mem_addr [NL];
  logic [31:0] o_mem_wdata [NL];

  logic        s_if_gnt [NL];
  logic        s_d_gnt [NL];
  logic        s_stall_if [NL];
  logic        s_stall_mem [NL];
  logic        s_if_valid [NL];
  logic        s_d_valid [NL];
  logic [31:0] s_if_rdata [NL];
  logic [31:0] s_d_rdata [NL];
  logic        s_mem_en [NL];

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0000_0011;
      1:       return 32'h0000_0022;
      2:       return 32'h0000_0033;
      16:      return 32'hFFFF_FFFF;
      default: return (32'(i) * 32'h0103_0507) ^ 32'hA5C3_5A3C;
    endcase
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lat
    localparam int L = g + 1;
    mem_arbiter_if bus ();

    mem_arbiter #(.LATENCY(L), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign bus.if_req   = if_req;
    assign bus.if_addr  = if_addr;
    assign bus.if_flush = if_flush;
    assign bus.d_req    = d_req;
    assign bus.d_we     = d_we;
    assign bus.d_wstrb  = d_wstrb;
    assign bus.d_addr   = d_addr;
    assign bus.d_wdata  = d_wdata;

    assign o_if_gnt[g]    = bus.if_gnt;
    assign o_d_gnt[g]     = bus.d_gnt;
    assign o_stall_if[g]  = bus.stall_if;
    assign o_stall_mem[g] = bus.stall_mem;
    assign o_if_valid[g]  = bus.if_valid;
    assign o_d_valid[g]   = bus.d_valid;
    assign o_if_rdata[g]  = bus.if_rdata;
    assign o_d_rdata[g]   = bus.d_rdata;
    assign o_mem_en[g]    = bus.mem_en;
    assign o_mem_we[g]    = bus.mem_we;
    assign o_mem_wstrb[g] = bus.mem_wstrb;
    assign o_mem_addr[g]  = bus.mem_addr;
    assign o_mem_wdata[g] = bus.mem_wdata;

    // Single-ported synchronous memory with an L-deep read pipeline;
    // random junk on mem_rdata when no read is emerging.
    logic [31:0] mem [256];
    logic        pv [L];
    logic [31:0] pd [L];
    logic [31:0] junk;

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      for (int i = 0; i < L; i++) begin
        pv[i] = 1'b0;
        pd[i] = 32'b0;
      end
      junk = 32'hBAD0_BAD0;
    end

    always @(posedge clk) begin
      junk <= $urandom;
      if (bus.mem_en && bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      pv[0] <= bus.mem_en & ~bus.mem_we;
      pd[0] <= mem[bus.mem_addr[9:2]];
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end

    assign bus.mem_rdata = pv[L-1] ? pd[L-1] : junk;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
  } ev_t;

  ev_t         glog [LOGN];
  logic        flog [LOGN];
  logic        rlog [LOGN];
  logic [31:0] ref_mem [256];
  int          m_starve;
  logic        m_ig;
  logic        m_dg;
  int          cyc;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0b, expected %0b", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    logic        ig;
    logic        dg;
    logic [31:0] w;
    logic [31:0] e_addr;
    ev_t         ev;
    ig = if_req & ~if_flush & ~reset & (~d_req | (m_starve == LIMIT));
    dg = d_req & ~reset & ~ig;
    m_ig = ig;
    m_dg = dg;
    flog[cyc] = if_flush;
    rlog[cyc] = reset;
    ev.kind = K_NONE;
    ev.data = 32'b0;
    if (ig) begin
      ev.kind = K_FETCH;
      ev.data = ref_mem[if_addr[9:2]];
    end else if (dg && !d_we) begin
      ev.kind = K_LOAD;
      ev.data = ref_mem[d_addr[9:2]];
    end else if (dg) begin
      w = ref_mem[d_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (d_wstrb[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
      ref_mem[d_addr[9:2]] = w;
      ev.kind = K_STORE;
    end
    glog[cyc] = ev;
    e_addr = ig ? if_addr : (dg ? d_addr : 32'b0);

    for (int l = 0; l < NL; l++) begin
      int          lat;
      logic        live;
      logic        e_iv;
      logic        e_dv;
      logic [31:0] e_ir;
      logic [31:0] e_dr;
      ev_t         e;
      lat  = l + 1;
      chk1($sformatf("L%0d if_gnt", lat), o_if_gnt[l], ig);
      chk1($sformatf("L%0d d_gnt", lat), o_d_gnt[l], dg);
      chk1($sformatf("L%0d stall_if", lat), o_stall_if[l], if_req & ~ig);
      chk1($sformatf("L%0d stall_mem", lat), o_stall_mem[l], d_req & ~dg);
      chk1($sformatf("L%0d mem_en", lat), o_mem_en[l], ig | dg);
      chk1($sformatf("L%0d mem_we", lat), o_mem_we[l], dg & d_we);
      chk($sformatf("L%0d mem_addr", lat), o_mem_addr[l], e_addr);
      if (dg && d_we) begin
        chk($sformatf("L%0d mem_wdata", lat), o_mem_wdata[l], d_wdata);
        chk($sformatf("L%0d mem_wstrb", lat), 32'(o_mem_wstrb[l]), 32'(d_wstrb));
      end else if (!(ig || dg)) begin
        chk($sformatf("L%0d idle mem_wdata", lat), o_mem_wdata[l], 32'b0);
        chk($sformatf("L%0d idle mem_wstrb", lat), 32'(o_mem_wstrb[l]), 32'b0);
      end
      e_iv = 1'b0;
      e_dv = 1'b0;
      e_ir = 32'b0;
      e_dr = 32'b0;
      if (cyc >= lat) begin
        e    = glog[cyc - lat];
        live = (e.kind != K_NONE);
        for (int c = cyc - lat + 1; c <= cyc; c++) begin
          if (rlog[c]) live = 1'b0;
          if (flog[c] && e.kind == K_FETCH) live = 1'b0;
        end
        if (live && e.kind == K_FETCH) begin
          e_iv = 1'b1;
          e_ir = e.data;
        end else if (live) begin
          e_dv = 1'b1;
          e_dr = e.data;
        end
      end
      chk1($sformatf("L%0d if_valid", lat), o_if_valid[l], e_iv);
      chk($sformatf("L%0d if_rdata", lat), o_if_rdata[l], e_ir);
      chk1($sformatf("L%0d d_valid", lat), o_d_valid[l], e_dv);
      chk($sformatf("L%0d d_rdata", lat), o_d_rdata[l], e_dr);
    end

    if (reset || ig || !if_req) m_starve = 0;
    else if (dg && !if_flush && m_starve < LIMIT) m_starve = m_starve + 1;
  endtask

  // One clock cycle: sample mid-cycle, check, then advance past the edge.
  task automatic tick();
    @(negedge clk);
    s_if_gnt    = o_if_gnt;
    s_d_gnt     = o_d_gnt;
    s_stall_if  = o_stall_if;
    s_stall_mem = o_stall_mem;
    s_if_valid  = o_if_valid;
    s_d_valid   = o_d_valid;
    s_if_rdata  = o_if_rdata;
    s_d_rdata   = o_d_rdata;
    s_mem_en    = o_mem_en;
    model_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    if_req   = 1'b0;
    if_addr  = 32'b0;
    if_flush = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_wstrb  = 4'b0;
    d_addr   = 32'b0;
    d_wdata  = 32'b0;
  endtask

  typedef struct {
    logic ir;
    logic dr;
    logic fl;
    logic rs;
    logic e_ig;
    logic e_dg;
    logic e_si;
    logic e_sm;
  } vec_t;

  vec_t        tbl [8];
  logic [7:0]  contend_f;
  logic        f_take;
  logic        d_take;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    cyc      = 0;
    m_starve = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // Reset state with both requests asserted.
    set_idle();
    reset  = 1'b1;
    if_req = 1'b1;
    d_req  = 1'b1;
    tick();
    chk1("reset if_gnt", s_if_gnt[0], 1'b0);
    chk1("reset d_gnt", s_d_gnt[0], 1'b0);
    chk1("reset mem_en", s_mem_en[0], 1'b0);
    chk1("reset stall_if", s_stall_if[0], 1'b1);
    chk1("reset stall_mem", s_stall_mem[0], 1'b1);
    chk1("reset d_valid", s_d_valid[3], 1'b0);
    set_idle();
    tick();
    reset = 1'b0;

    // Single-cycle arbitration table, each row followed by an idle cycle.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      set_idle();
      if_req   = tbl[i].ir;
      if_addr  = 32'h80;
      d_req    = tbl[i].dr;
      d_addr   = 32'h100;
      if_flush = tbl[i].fl;
      reset    = tbl[i].rs;
      tick();
      chk1($sformatf("tbl%0d if_gnt", i), s_if_gnt[0], tbl[i].e_ig);
      chk1($sformatf("tbl%0d d_gnt", i), s_d_gnt[0], tbl[i].e_dg);
      chk1($sformatf("tbl%0d stall_if", i), s_stall_if[0], tbl[i].e_si);
      chk1($sformatf("tbl%0d stall_mem", i), s_stall_mem[0], tbl[i].e_sm);
      set_idle();
      reset = 1'b0;
      tick();
    end
    for (int i = 0; i < 5; i++) tick();

    // Fetch-only stream at LATENCY 1.
    for (int i = 0; i < 4; i++) begin
      set_idle();
      if (i < 3) begin
        if_req  = 1'b1;
        if_addr = 32'(4 * i);
      end
      tick();
      if (i < 3) begin
        chk1($sformatf("fetch%0d if_gnt", i), s_if_gnt[0], 1'b1);
        chk1($sformatf("fetch%0d stall_if", i), s_stall_if[0], 1'b0);
      end
      if (i > 0) begin
        chk1($sformatf("fetch%0d if_valid", i), s_if_valid[0], 1'b1);
        chk($sformatf("fetch%0d if_rdata", i), s_if_rdata[0], 32'(8'h11 * (i)));
      end
    end

    // Contention: grants D,D,D,F repeating.
    set_idle();
    tick();
    contend_f = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      set_idle();
      if_req  = 1'b1;
      if_addr = 32'h0C;
      d_req   = 1'b1;
      d_addr  = 32'h20 + 32'(4 * i);
      tick();
      chk1($sformatf("contend%0d if_gnt", i), s_if_gnt[0], contend_f[i]);
      chk1($sformatf("contend%0d d_gnt", i), s_d_gnt[0], ~contend_f[i]);
      chk1($sformatf("contend%0d stall_if", i), s_stall_if[0], ~contend_f[i]);
    end
    set_idle();
    for (int i = 0; i < 5; i++) tick();

    // Store then dependent load at LATENCY 2.
    for (int i = 0; i < 4; i++) begin
      set_idle();
      if (i == 0) begin
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_wstrb = 4'b0011;
        d_addr  = 32'h40;
        d_wdata = 32'hDEAD_BEEF;
      end else if (i == 1) begin
        d_req  = 1'b1;
        d_addr = 32'h40;
      end
      tick();
      if (i < 2) chk1($sformatf("st_ld%0d d_gnt", i), s_d_gnt[1], 1'b1);
      if (i == 1) chk1("st_ld early d_valid", s_d_valid[1], 1'b0);
      if (i >= 2) chk1($sformatf("st_ld%0d d_valid", i), s_d_valid[1], 1'b1);
      if (i == 2) chk("store d_rdata", s_d_rdata[1], 32'h0);
      if (i == 3) chk("load d_rdata", s_d_rdata[1], 32'hFFFF_BEEF);
    end
    set_idle();
    for (int i = 0; i < 5; i++) tick();

    // Flush at LATENCY 3 kills three in-flight fetches, not the load.
    for (int i = 0; i < 8; i++) begin
      set_idle();
      if (i < 3) begin
        if_req  = 1'b1;
        if_addr = 32'h10 + 32'(4 * i);
      end else if (i == 3) begin
        if_flush = 1'b1;
        if_req   = 1'b1;
        if_addr  = 32'h200;
        d_req    = 1'b1;
        d_addr   = 32'h44;
      end
      tick();
      if (i == 3) begin
        chk1("flush if_gnt", s_if_gnt[2], 1'b0);
        chk1("flush d_gnt", s_d_gnt[2], 1'b1);
      end
      chk1($sformatf("flush%0d if_valid", i), s_if_valid[2], 1'b0);
      if (i == 6) chk1("flush load d_valid", s_d_valid[2], 1'b1);
    end
    set_idle();
    for (int i = 0; i < 5; i++) tick();

    // Reset mid-flight at LATENCY 4.
    for (int i = 0; i < 7; i++) begin
      set_idle();
      if_req  = 1'b1;
      if_addr = 32'h20;
      d_req   = 1'b1;
      d_addr  = 32'h24 + 32'(4 * (i % 2));
      reset   = (i == 2);
      tick();
      if (i < 2) chk1($sformatf("rstmid%0d d_gnt", i), s_d_gnt[3], 1'b1);
      if (i >= 3) begin
        chk1($sformatf("rstmid%0d d_gnt", i), s_d_gnt[3], i != 6);
        chk1($sformatf("rstmid%0d if_gnt", i), s_if_gnt[3], i == 6);
        chk1($sformatf("rstmid%0d d_valid", i), s_d_valid[3], 1'b0);
        chk1($sformatf("rstmid%0d if_valid", i), s_if_valid[3], 1'b0);
      end
    end
    reset = 1'b0;
    set_idle();
    for (int i = 0; i < 5; i++) tick();

    // Random traffic; a denied request holds until granted or dropped.
    f_take = 1'b1;
    d_take = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      if_flush = ($urandom_range(0, 9) == 0);
      if (f_take || !if_req) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (d_take || !d_req) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_wstrb = 4'($urandom);
        d_addr  = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
        d_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
      tick();
      f_take = m_ig | if_flush;
      d_take = m_dg;
    end
    reset = 1'b0;
    set_idle();
    for (int i = 0; i < 6; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported synchronous memory between the fetch port (instruction fetch) and the data port (load/store in the MEM stage) of the pipelined core. Each cycle it grants at most one port, drives the memory, and returns read data to the owning port a fixed LATENCY cycles later. It also produces the stall signals that freeze the requesting pipeline stage while that stage is denied.

## Interface
- LATENCY, 1: memory read latency in cycles; legal range 1..4.
- STARVE_LIMIT, 3: maximum number of consecutive data grants while a fetch request is pending; legal range 1..15.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_flush  in  1  branch-taken flush; cancels fetch traffic.
- if_gnt  out  1  fetch request accepted this cycle.
- if_valid  out  1  fetch response valid.
- if_rdata  out  32  fetch response data.
- stall_if  out  1  if_req & ~if_gnt.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_wstrb  in  4  byte write enables, used when d_we = 1.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_valid  out  1  data response valid; pulses for both loads and stores.
- d_rdata  out  32  load data; 0 for store responses.
- stall_mem  out  1  d_req & ~d_gnt.
- mem_en  out  1  memory access issued this cycle.
- mem_we  out  1  write strobe to memory.
- mem_wstrb  out  4  byte enables to memory.
- mem_addr  out  32  address to memory.
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32  memory read data; valid LATENCY cycles after the mem_en cycle.

## Operation
- The grant logic is combinational from the requests, if_flush and the starvation counter. Everything else is registered.
- Arbitration:
  - if_flush = 1 forces if_gnt = 0.
  - Otherwise, with only one request asserted, that request is granted.
  - When both requests are asserted, data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt (4 bits):
  - Increments when d_gnt & if_req & ~if_flush.
  - Clears when if_gnt = 1 or if_req = 0.
  - Saturates at STARVE_LIMIT.
- Memory issue:
  - mem_en = if_gnt | d_gnt.
  - mem_addr and mem_wdata/mem_wstrb/mem_we come from the granted port.
  - For fetches, mem_we = 0 and mem_wstrb = 0.
- Tag pipeline: a LATENCY-deep shift register carries {valid, owner, is_store} for each issued access. Stage 0 is loaded from the grant in the issue cycle.
- Response at the tag output:
  - Owner fetch: if_valid = 1, if_rdata = mem_rdata.
  - Owner data load: d_valid = 1, d_rdata = mem_rdata.
  - Owner data store: d_valid = 1, d_rdata = 0.
- Flush: if_flush clears the valid bit of every fetch-owned tag in flight. This includes a tag emerging in the flush cycle, so if_valid = 0 in that cycle. Data tags are unaffected.
- Requesters hold their req/addr/data stable until the corresponding gnt. A requester may drop req before being granted; no side effect.
- When a port is not in use: if_rdata/d_rdata = 0 whenever the corresponding valid = 0, and mem_addr/mem_wdata/mem_wstrb = 0 when mem_en = 0.

## Timing
- Reset values:
  - if_gnt, d_gnt, mem_en, mem_we = 0 while reset = 1.
  - if_valid, d_valid = 0; if_rdata, d_rdata = 0.
  - starve_cnt = 0; all tags invalid.
  - stall_if = if_req, stall_mem = d_req.
- Reset mid-operation: all in-flight responses are discarded, and no valid appears in the LATENCY cycles after reset deasserts.
- Latency: for an access granted in cycle k, the response valid appears in cycle k+LATENCY, lasts exactly 1 cycle, and has no backpressure.
- Throughput: one access per cycle; back-to-back grants produce back-to-back responses in issue order.
- A store is visible to a load granted in the very next cycle; the memory is write-first per cycle order.
- Simultaneous events:
  - if_flush together with an emerging fetch tag: the response is dropped.
  - if_flush together with an emerging data tag: the response is delivered.
  - if_flush together with d_req: the data access is granted.

## Test plan
- Fetch only, LATENCY=1: if_req=1, if_addr=0x00,0x04,0x08 on consecutive cycles, memory holding 0x11,0x22,0x33 -> if_gnt=1 every cycle; if_valid on cycles k+1..k+3 with if_rdata 0x11,0x22,0x33; stall_if=0.
- Contention, STARVE_LIMIT=3: if_req and d_req held high for 8 cycles -> grant sequence D,D,D,F,D,D,D,F; stall_if=1 on every D cycle.
- Store then load, LATENCY=2: store 0xDEADBEEF with wstrb=4'b0011 to 0x40 (old value 0xFFFFFFFF), then load 0x40 the next cycle -> store response d_valid with d_rdata=0; load response 0xFFFFBEEF two cycles after the load grant.
- Flush, LATENCY=3: three fetches issued, if_flush pulsed on the cycle after the third grant -> no if_valid for any of the three; if_gnt=0 in the flush cycle; a data load issued in the same window still returns d_valid.
- Reset mid-flight, LATENCY=4: two loads granted, reset for 1 cycle -> d_valid stays 0 for the next 4 cycles; starve_cnt=0; the next request is granted immediately.
- LATENCY sweep 1..4 with a random interleaving of requests and flushes -> every response arrives exactly LATENCY cycles after its grant, in order, and matches a reference memory model.
